// File: rtl/core_pkg.sv
// Shared core definitions for the fetch front end: machine width, PC step,
// the canonical NOP encoding and the {pc, instr} record carried by the fetch queue.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets may carry junk in the low bits; fetch is always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// sync_fifo: single-clock circular FIFO with push/pop/flush and an occupancy count.
// Push while full is accepted only when a pop frees a slot in the same cycle.
// Flush empties the FIFO and takes priority over push and pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; validity is tracked by cnt alone, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential-PC fetch stage between imem and decode.
// Issues word requests under a credit limit so every response has a reserved
// queue slot, tracks in-flight PCs, and hands in-order (pc, instr) pairs to decode.
// A redirect flushes everything and discards responses still in flight.
// Optional feature: define FETCH_PERF_CNT_EN to build the flush/starvation counters;
// otherwise perf_flush_cnt and perf_empty_cnt are constant zero.
module instr_fetch_queue
    import core_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_empty_cnt
);

    localparam int               CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;   // issued, response not yet seen (includes ones to drop)
    logic [CNT_W-1:0] drop;          // responses still owed from before the last redirect

    logic             issue;
    logic             rsp;
    logic             rsp_keep;
    logic             trk_pop;
    logic             q_pop;

    logic [31:0]      trk_head;
    logic             trk_full;
    logic             trk_empty;
    logic [CNT_W-1:0] trk_count;

    fetch_entry_t     q_wdata;
    fetch_entry_t     q_rdata;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;

    // Credit: queued entries plus everything in flight never exceed DEPTH.
    // Reset and redirect cycles never issue.
    assign imem_req  = !rst && !redirect_valid &&
                       (({1'b0, q_count} + {1'b0, outstanding}) < CREDIT_LIMIT);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp      = imem_rvalid && (outstanding != '0);
    assign trk_pop  = rsp && (drop == '0);
    assign rsp_keep = trk_pop && !redirect_valid;
    assign q_pop    = out_valid && out_ready && !redirect_valid;

    assign q_wdata.pc    = trk_head;
    assign q_wdata.instr = imem_rdata;

    assign out_valid = !q_empty;
    assign out_pc    = out_valid ? q_rdata.pc    : '0;
    assign out_instr = out_valid ? q_rdata.instr : '0;

    // PCs of requests whose responses will be kept, oldest first.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_tracker (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .wr_data (fetch_pc),
        .pop     (trk_pop),
        .flush   (redirect_valid),
        .rd_data (trk_head),
        .full    (trk_full),
        .empty   (trk_empty),
        .count   (trk_count)
    );

    // In-order (pc, instr) queue presented to decode.
    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (rsp_keep),
        .wr_data (q_wdata),
        .pop     (q_pop),
        .flush   (redirect_valid),
        .rd_data (q_rdata),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // Fetch PC, in-flight count and drop count; redirect overrides normal sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp);
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
                drop     <= outstanding - CNT_W'(rsp);
            end else begin
                if (issue)               fetch_pc <= fetch_pc + PC_STEP;
                if (rsp && drop != '0)   drop     <= drop - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters for redirects taken and cycles decode waited on an empty queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flush_cnt <= '0;
            perf_empty_cnt <= '0;
        end else begin
            if (redirect_valid && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (out_ready && !out_valid && perf_empty_cnt != 32'hFFFF_FFFF)
                perf_empty_cnt <= perf_empty_cnt + 32'd1;
        end
    end
`else
    assign perf_flush_cnt = 32'h0;
    assign perf_empty_cnt = 32'h0;
`endif

    // Simulation-time invariants: protocol, no overflow, tracker consistent with in-flight count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid && outstanding == '0));
            assert (!(rsp_keep && q_full && !q_pop));
            assert (!(issue && trk_full && !trk_pop));
            assert (!(trk_pop && trk_empty));
            assert (trk_count <= outstanding);
        end
    end

endmodule
